rom_fetch_controller: RTL

//  Instruction-fetch sequencer for the program ROM: holds the PC and drives the ROM byte address.
//  ROM is combinational and .text-based, so the controller captures its data into a one-entry output slot.

---
 rtl/rom_fetch_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rom_fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational program ROM and holds one
// fetched instruction for decode. Define FETCH_BOUNDS_CHECK_EN to enable the fetch-window fault.
module rom_fetch_controller #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic                  Halt_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Addr_i,
  output logic [DATA_WIDTH-1:0] Rom_Address_o,
  input  logic [DATA_WIDTH-1:0] Rom_Data_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic [DATA_WIDTH-1:0] Fetch_Count_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_Addr_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StFault} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic                  pc_legal;
  logic                  accept;
  logic                  slot_free;

`ifdef FETCH_BOUNDS_CHECK_EN
  // One extra bit keeps the window end from wrapping when TEXT_BASE sits near the top.
  localparam logic [DATA_WIDTH:0] WinLo = {1'b0, TEXT_BASE};
  localparam logic [DATA_WIDTH:0] WinHi = WinLo + (DATA_WIDTH + 1)'(4 * MEMORY_DEPTH);

  assign pc_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} >= WinLo) && ({1'b0, pc_q} < WinHi);
`else
  logic unused_depth;
  assign unused_depth = ^MEMORY_DEPTH;
  assign pc_legal     = 1'b1;
`endif

  assign accept    = valid_q & Ready_i;
  assign slot_free = ~valid_q | Ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= TEXT_BASE;
      instr_q      <= '0;
      pc_out_q     <= '0;
      count_q      <= '0;
      fault_addr_q <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      count_q      <= count_d;
      fault_addr_q <= fault_addr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    count_d      = count_q;
    fault_addr_d = fault_addr_q;
    valid_d      = valid_q;
    fault_d      = fault_q;

    if (accept) begin
      count_d = count_q + DATA_WIDTH'(1);
    end

    // A redirect flushes the slot after any same-cycle acceptance has been counted.
    if (Redirect_i) begin
      pc_d    = Redirect_Addr_i;
      valid_d = 1'b0;
      fault_d = 1'b0;
      if (state_q == StFetch && Halt_i) begin
        state_d = StIdle;
      end else if (state_q != StIdle) begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) valid_d = 1'b0;
          if (Start_i) state_d = StFetch;
        end
        StFetch: begin
          if (Halt_i) begin
            state_d = StIdle;
            if (accept) valid_d = 1'b0;
          end else if (slot_free) begin
            if (pc_legal) begin
              instr_d  = Rom_Data_i;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + DATA_WIDTH'(4);
            end else begin
              valid_d      = 1'b0;
              fault_d      = 1'b1;
              fault_addr_d = pc_q;
              state_d      = StFault;
            end
          end
        end
        StFault: valid_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    Rom_Address_o = pc_q;
    Instr_o       = instr_q;
    PC_o          = pc_out_q;
    Valid_o       = valid_q;
    Fetch_Count_o = count_q;
    Fault_o       = fault_q;
    Fault_Addr_o  = fault_addr_q;
  end

endmodule
